machine_ctrl: RTL and testbench

MACHINE_CTRL -- requirements
Module: machine_ctrl

---
 rtl/machine_ctrl.sv | 119 +++++++++++
 tb/tb_machine_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_ctrl.sv
// Sequencer that serially drives a small JK state machine with a latched pattern and captures its F output.
// Optional continuous re-run of the latched pattern is enabled by defining MACHINE_CTRL_REPEAT_EN.
module machine_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CW      = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic               stop,
  input  logic               repeat_req,  // "repeat" is a reserved word, so the run-again request uses this name
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [CW-1:0]      len,
  input  logic               F,
  input  logic [2:0]         S,
  output logic               x,
  output logic               machine_rst,
  output logic               busy,
  output logic               done,
  output logic [MAX_LEN-1:0] result,
  output logic [CW-1:0]      f_count,
  output logic [2:0]         last_s
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, FLUSH, DONE} state_t;

  localparam logic [CW-1:0] MAX_LEN_CW = CW'(MAX_LEN);

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] pat_sh;
  logic [CW-1:0]      len_q;
  logic [CW-1:0]      bit_idx;
  logic               rep_q;
  logic               rst_q;
  logic               accept;
  logic               capture;

  assign accept  = (state == IDLE) && start && !stop;
  // A capture samples F one cycle after the bit was driven, so it trails bit_idx by one.
  assign capture = ((state == RUN) && (bit_idx != '0)) || (state == FLUSH);
  assign pat_sh  = pat_q >> bit_idx;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt   = state;
    x           = 1'b0;
    machine_rst = rst_q;
    busy        = (state != IDLE);
    done        = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = CLR;
      CLR: begin
        machine_rst = 1'b1;
        state_nxt   = (len_q != '0) ? RUN : DONE;
      end
      RUN: begin
        x = pat_sh[0];
        if (bit_idx == len_q - CW'(1)) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = DONE;
      DONE: begin
        done = 1'b1;
`ifdef MACHINE_CTRL_REPEAT_EN
        state_nxt = rep_q ? CLR : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    if ((state != IDLE) && stop) state_nxt = IDLE;
  end

`ifndef MACHINE_CTRL_REPEAT_EN
  logic unused_repeat;
  assign unused_repeat = rep_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= 1'b0;
      bit_idx <= '0;
      rst_q   <= 1'b1;
      result  <= '0;
      f_count <= '0;
      last_s  <= '0;
    end else begin
      rst_q <= 1'b0;
      if (accept) begin
        pat_q   <= pattern;
        len_q   <= (len > MAX_LEN_CW) ? MAX_LEN_CW : len;
        rep_q   <= repeat_req;
        result  <= '0;
        f_count <= '0;
      end
      if (state == CLR) begin
        bit_idx <= '0;
        result  <= '0;
        f_count <= '0;
      end
      if (state == RUN) bit_idx <= bit_idx + CW'(1);
      if (capture) begin
        result  <= result | (MAX_LEN'(F) << (bit_idx - CW'(1)));
        f_count <= f_count + CW'(F);
        last_s  <= S;
      end
    end
  end

endmodule

// File: tb/tb_machine_ctrl.sv
// Bench for machine_ctrl: plant F = x delayed one cycle, run-offset reference model checked every cycle,
// plus directed runs with literal expectations. Define MACHINE_CTRL_REPEAT_EN to check the re-run build.
module tb_machine_ctrl;

`ifdef MACHINE_CTRL_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0, stop = 1'b0, repeat_req = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic       F = 1'b0;
  logic [2:0] S;
  logic       x, machine_rst, busy, done;
  logic [7:0] result;
  logic [3:0] f_count;
  logic [2:0] last_s;

  int n_checks = 0;
  int n_err = 0;

  machine_ctrl dut (
    .CLK(CLK), .RESET(RESET), .start(start), .stop(stop), .repeat_req(repeat_req),
    .pattern(pattern), .len(len), .F(F), .S(S), .x(x), .machine_rst(machine_rst),
    .busy(busy), .done(done), .result(result), .f_count(f_count), .last_s(last_s)
  );

  always #5 CLK = ~CLK;

  // Controlled machine: F follows x one cycle later, cleared while held in reset.
  always @(posedge CLK) F <= machine_rst ? 1'b0 : x;
  assign S = {2'b00, F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is tracked as a cycle offset t from acceptance (t=1 is the clear cycle).
  bit         m_valid = 1'b0;
  bit         m_rst = 1'b0;
  bit         m_active = 1'b0;
  bit         m_rep = 1'b0;
  int         m_t = 0;
  int         m_len = 0;
  logic [7:0] m_pat = '0;
  logic [7:0] m_res = '0;
  int         m_cnt = 0;
  logic [2:0] m_ls = '0;

  always @(posedge CLK) begin : model
    bit         act, rep;
    int         t, l, cnt;
    logic [7:0] p, res;
    logic [2:0] ls;
    act = m_active; rep = m_rep; t = m_t; l = m_len;
    p = m_pat; res = m_res; cnt = m_cnt; ls = m_ls;
    if (RESET) begin
      act = 1'b0; rep = 1'b0; res = '0; cnt = 0; ls = '0;
      m_rst   <= 1'b1;
      m_valid <= 1'b1;
    end else begin
      m_rst <= 1'b0;
      if (!act) begin
        if (start && !stop) begin
          p = pattern; l = (len > 4'd8) ? 8 : int'(len); rep = repeat_req;
          res = '0; cnt = 0; act = 1'b1; t = 1;
        end
      end else begin
        if (t == 1) begin res = '0; cnt = 0; end
        if (t >= 3 && t <= l + 2) begin
          res[t-3] = p[t-3];
          cnt += int'(p[t-3]);
          ls = {2'b00, p[t-3]};
        end
        if (stop) act = 1'b0;
        else if (t == ((l == 0) ? 2 : l + 3)) begin
          if (REP_EN && rep) t = 1;
          else act = 1'b0;
        end else t++;
      end
    end
    m_active <= act; m_rep <= rep; m_t <= t; m_len <= l;
    m_pat <= p; m_res <= res; m_cnt <= cnt; m_ls <= ls;
  end

  initial begin : compare
    logic exp_x, exp_rst, exp_done;
    forever begin
      @(posedge CLK);
      #2;
      if (m_valid) begin
        exp_x    = m_active && m_t >= 2 && m_t <= m_len + 1 && m_pat[m_t-2];
        exp_rst  = m_rst || (m_active && m_t == 1);
        exp_done = m_active && m_t == ((m_len == 0) ? 2 : m_len + 3);
        check("model_x", 32'(x), 32'(exp_x));
        check("model_machine_rst", 32'(machine_rst), 32'(exp_rst));
        check("model_busy", 32'(busy), 32'(m_active));
        check("model_done", 32'(done), 32'(exp_done));
        check("model_result", 32'(result), 32'(m_res));
        check("model_f_count", 32'(f_count), 32'(m_cnt[3:0]));
        check("model_last_s", 32'(last_s), 32'(m_ls));
      end
    end
  end

  logic [63:0] xlog;

  task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic r);
    start = 1'b1; pattern = p; len = l; repeat_req = r;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Counts cycles from acceptance until done is seen; c0 is the count at the current negedge.
  task automatic wait_done(input int c0, output int c);
    c = c0;
    xlog = '0;
    xlog[c] = x;
    while (done !== 1'b1 && c < 60) begin
      @(negedge CLK);
      c++;
      xlog[c] = x;
    end
  endtask

  initial begin : stim
    int c;
    // Reset values while RESET is held, then release.
    @(negedge CLK);
    check("rst_machine_rst", 32'(machine_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    check("rst_outputs", {13'd0, result, f_count, last_s}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_release_machine_rst", 32'(machine_rst), 32'd0);

    // Full-length run.
    launch(8'b1011_0110, 4'd8, 1'b0);
    wait_done(1, c);
    check("run8_latency", 32'(c), 32'd11);
    check("run8_x_seq", 32'(xlog[9:2]), 32'b1011_0110);
    check("run8_result", 32'(result), 32'b1011_0110);
    check("run8_f_count", 32'(f_count), 32'd5);
    @(negedge CLK);
    check("run8_idle", 32'(busy), 32'd0);

    // Zero-length run.
    launch(8'h5A, 4'd0, 1'b0);
    wait_done(1, c);
    check("len0_latency", 32'(c), 32'd2);
    check("len0_x_quiet", 32'(xlog[31:0]), 32'd0);
    check("len0_result", {24'd0, result}, 32'd0);
    check("len0_f_count", 32'(f_count), 32'd0);
    @(negedge CLK);

    // Stop in the second RUN cycle.
    launch(8'hFF, 4'd3, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    stop = 1'b1;
    @(negedge CLK);
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_result", 32'(result), 32'h01);
    check("stop_f_count", 32'(f_count), 32'd1);
    repeat (3) begin
      @(negedge CLK);
      check("stop_no_done", 32'(done), 32'd0);
    end

    // start during RUN is ignored; start+stop in IDLE stays idle.
    launch(8'h3C, 4'd5, 1'b0);
    @(negedge CLK);
    start = 1'b1; pattern = 8'hFF; len = 4'd2;
    @(negedge CLK);
    start = 1'b0;
    wait_done(3, c);
    check("ignore_start_latency", 32'(c), 32'd8);
    check("ignore_start_result", 32'(result), 32'h1C);
    check("ignore_start_f_count", 32'(f_count), 32'd3);
    @(negedge CLK);
    start = 1'b1; stop = 1'b1;
    @(negedge CLK);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", 32'(busy), 32'd0);
    @(negedge CLK);
    check("start_stop_still_idle", 32'(busy), 32'd0);

    // Over-long len is clamped.
    launch(8'h96, 4'd12, 1'b0);
    wait_done(1, c);
    check("clamp_latency", 32'(c), 32'd11);
    check("clamp_result", 32'(result), 32'h96);
    @(negedge CLK);

    // Reset mid-run.
    launch(8'hA5, 4'd8, 1'b0);
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_machine_rst", 32'(machine_rst), 32'd1);
    check("midrst_outputs", {13'd0, result, f_count, last_s}, 32'd0);
    check("midrst_x_done", {30'd0, x, done}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    check("midrst_release", 32'(machine_rst), 32'd0);

    // Repeat request.
    launch(8'h03, 4'd2, 1'b1);
    wait_done(1, c);
    check("rep_first_latency", 32'(c), 32'd5);
    check("rep_first_result", 32'(result), 32'h03);
    @(negedge CLK);
    if (REP_EN) begin
      wait_done(1, c);
      check("rep_second_latency", 32'(c), 32'd5);
      check("rep_second_result", 32'(result), 32'h03);
      stop = 1'b1;
      @(negedge CLK);
      stop = 1'b0;
    end else begin
      repeat (4) @(negedge CLK);
    end
    check("rep_end_idle", 32'(busy), 32'd0);
    repeat_req = 1'b0;
    @(negedge CLK);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      RESET      = ($urandom_range(0, 299) == 0);
      start      = ($urandom_range(0, 3) == 0);
      stop       = ($urandom_range(0, 19) == 0);
      repeat_req = 1'($urandom);
      pattern    = 8'($urandom);
      len        = 4'($urandom);
      @(negedge CLK);
    end
    RESET = 1'b1; start = 1'b0; stop = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
